// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart controller: register map, status bits, TX states.
package uart_ctrl_pkg;

    // Register indices on the peripheral bus
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DIVLO  = 3'd2;
    localparam logic [2:0] ADDR_DIVHI  = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    // Bit positions inside the STATUS register
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_IDLE  = 2;
    localparam int ST_OVERRUN  = 3;

    // Bit positions inside the CTRL register
    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_LOAD  = 2'b01,
        TX_GUARD = 2'b10,
        TX_BUSY  = 2'b11
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with an extra pointer bit for full/empty. A pop is applied before a
// push in the same cycle, so a full FIFO accepts a push when it is also popped,
// and an empty FIFO ignores the pop while still accepting the push.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted pops and pushes
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // Store pushed bytes
    always_ff @(posedge clk) begin
        // NOTE: storage array is not reset; pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-facing uart controller: bit-clock divider, TX FIFO + load sequencer,
// RX FIFO with sticky overrun, register file and level interrupt.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd103,
    parameter int          TXDEPTH   = 4,
    parameter int          RXDEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    output logic       bitxce,
    output logic       load,
    output logic [7:0] txd,
    input  logic       txbusy,
    input  logic       bytercvd,
    input  logic [7:0] rxq
);

    logic [15:0] div;
    logic [15:0] div_cnt;
    logic        rxie;
    logic        txie;
    logic        overrun;
    tx_state_t   tx_state;

    logic        wr_access;
    logic        rd_access;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        rx_drop;
    logic        tx_idle;
    logic [7:0]  status;
    logic [7:0]  rd_data;

    assign wr_access = cs && we;
    assign rd_access = cs && !we;
    assign tx_push   = wr_access && (addr == ADDR_DATA);
    assign tx_pop    = (tx_state == TX_LOAD);
    assign rx_pop    = rd_access && (addr == ADDR_DATA);
    // A byte is lost only when the RX FIFO is full and not being drained this cycle
    assign rx_drop   = bytercvd && rx_full && !(rx_pop && !rx_empty);
    assign tx_idle   = (tx_state == TX_IDLE) && tx_empty && !txbusy;

    uart_fifo #(.DEPTH(TXDEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (din),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    uart_fifo #(.DEPTH(RXDEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (bytercvd),
        .pop    (rx_pop),
        .din    (rxq),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_head)
    );

    // Assemble status byte and select read data for the addressed register
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        status = 8'h00;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_OVERRUN]  = overrun;

        rd_data = 8'h00;
        case (addr)
            ADDR_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: rd_data = status;
            ADDR_DIVLO:  rd_data = div[7:0];
            ADDR_DIVHI:  rd_data = div[15:8];
            ADDR_CTRL:   rd_data = {6'b0, txie, rxie};
            default:     rd_data = 8'h00;
        endcase
    end

    // Bit-clock divider: count down, reload from div at zero and pulse bitxce
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt <= DIV_RESET;
            bitxce  <= 1'b0;
        end else if (div_cnt == 16'd0) begin
            div_cnt <= div;
            bitxce  <= 1'b1;
        end else begin
            div_cnt <= div_cnt - 16'd1;
            bitxce  <= 1'b0;
        end
    end

    // Writable registers and the sticky overrun flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div     <= DIV_RESET;
            rxie    <= 1'b0;
            txie    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr_access) begin
                case (addr)
                    ADDR_DIVLO:  div[7:0]  <= din;
                    ADDR_DIVHI:  div[15:8] <= din;
                    ADDR_CTRL: begin
                        rxie <= din[CTRL_RXIE];
                        txie <= din[CTRL_TXIE];
                    end
                    ADDR_STATUS: if (din[ST_OVERRUN]) overrun <= 1'b0;
                    default: ;
                endcase
            end
            // A new overrun in the same cycle as a clear keeps the flag set
            if (rx_drop) overrun <= 1'b1;
        end
    end

    // Registered read data, updated only on a read access
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout <= 8'h00;
        end else if (rd_access) begin
            dout <= rd_data;
        end
    end

    // TX sequencer: hand one byte to the core, then wait out its busy period
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            load     <= 1'b0;
            txd      <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty && !txbusy) begin
                        tx_state <= TX_LOAD;
                        load     <= 1'b1;
                        txd      <= tx_head;
                    end
                end
                TX_LOAD: begin
                    tx_state <= TX_GUARD;
                    load     <= 1'b0;
                end
                // Core has not raised txbusy yet; skip one cycle before trusting it
                TX_GUARD: tx_state <= TX_BUSY;
                TX_BUSY: begin
                    if (!txbusy) tx_state <= TX_IDLE;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    load     <= 1'b0;
                end
            endcase
        end
    end

    // Level interrupt, registered from current FIFO and enable state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= (rxie && !rx_empty) || (txie && tx_empty) || (rxie && overrun);
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed testbench for uart_ctrl with a simple core model driving txbusy.
module tb_uart_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic       bitxce;
    logic       load;
    logic [7:0] txd;
    logic       txbusy;
    logic       bytercvd;
    logic [7:0] rxq;

    int checks = 0;
    int errors = 0;

    uart_ctrl #(.DIV_RESET(16'd103), .TXDEPTH(4), .RXDEPTH(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .irq      (irq),
        .bitxce   (bitxce),
        .load     (load),
        .txd      (txd),
        .txbusy   (txbusy),
        .bytercvd (bytercvd),
        .rxq      (rxq)
    );

    always #5 clk = ~clk;

    // Core model: busy for 20 cycles after each load, or held busy by the bench
    logic hold_busy = 1'b0;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        if (load)              busy_cnt <= 20;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign txbusy = (busy_cnt != 0) || hold_busy;

    // Load monitor, sampled on the falling edge
    int         cyc = 0;
    int         n_loads = 0;
    int         long_loads = 0;
    int         last_fall = 0;
    logic [7:0] load_log   [16];
    int         load_cyc   [16];
    int         fall_before[16];
    logic       prev_load = 1'b0;
    logic       prev_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_busy && !txbusy) last_fall = cyc;
        if (load) begin
            if (n_loads < 16) begin
                load_log[n_loads]    = txd;
                load_cyc[n_loads]    = cyc;
                fall_before[n_loads] = last_fall;
            end
            n_loads++;
            if (prev_load) long_loads++;
        end
        prev_load = load;
        prev_busy = txbusy;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        bytercvd = 1'b1; rxq = b;
        @(negedge clk);
        bytercvd = 1'b0;
    endtask

    logic [7:0] rd;
    logic       found;
    int         gap;
    logic [7:0] rx_vals [5];
    logic [7:0] full_vals [5];

    initial begin
        resetn = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
        bytercvd = 1'b0; rxq = 8'h00;
        rx_vals   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        full_vals = '{8'hA2, 8'hA3, 8'hA4, 8'h99, 8'h00};

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_dout",   dout,   8'h00);
        check("rst_irq",    irq,    1'b0);
        check("rst_bitxce", bitxce, 1'b0);
        check("rst_load",   load,   1'b0);
        check("rst_txd",    txd,    8'h00);
        resetn = 1'b1;

        // ---- Divider ----
        bus_read(3'd2, rd);  check("div_lo_reset", rd, 8'd103);
        bus_write(3'd2, 8'd3);
        bus_write(3'd3, 8'd0);
        bus_read(3'd2, rd);  check("div_lo", rd, 8'h03);
        bus_read(3'd3, rd);  check("div_hi", rd, 8'h00);
        bus_read(3'd1, rd);  check("status_reset", rd, 8'h04);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bitxce) found = 1'b1;
        end
        check("bitxce_seen", found, 1'b1);
        for (int k = 0; k < 3; k++) begin
            gap = 0; found = 1'b0;
            for (int i = 1; i <= 20 && !found; i++) begin
                @(negedge clk);
                if (bitxce) begin found = 1'b1; gap = i; end
            end
            check("bitxce_gap", gap, 16'd4);
        end

        // ---- TX sequencing ----
        bus_write(3'd0, 8'h41);
        bus_write(3'd0, 8'h42);
        repeat (80) @(negedge clk);
        check("tx_n_loads", n_loads, 16'd2);
        check("tx_byte0",   load_log[0], 8'h41);
        check("tx_byte1",   load_log[1], 8'h42);
        check("tx_single_cycle", long_loads, 16'd0);
        check("tx_load_after_fall", (load_cyc[1] - fall_before[1]) >= 1, 1'b1);
        check("tx_load_spacing",    (load_cyc[1] - load_cyc[0]) >= 4, 1'b1);
        bus_read(3'd1, rd);  check("tx_idle_end", rd, 8'h04);

        // ---- TX overflow ----
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) bus_write(3'd0, 8'(i));
        bus_read(3'd1, rd);  check("tx_full_after4", rd, 8'h02);
        bus_write(3'd0, 8'h05);
        bus_read(3'd1, rd);  check("tx_full_after5", rd, 8'h02);
        check("tx_no_load_while_busy", n_loads, 16'd2);
        hold_busy = 1'b0;
        repeat (130) @(negedge clk);
        check("ovf_n_loads", n_loads, 16'd6);
        for (int i = 0; i < 4; i++) check("ovf_byte", load_log[2+i], 8'(i + 1));
        bus_read(3'd1, rd);  check("ovf_idle_end", rd, 8'h04);

        // ---- RX FIFO and overrun ----
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h44); rx_byte(8'h55);
        bus_read(3'd1, rd);  check("rx_status_ovr", rd, 8'h0D);
        for (int i = 0; i < 5; i++) begin
            bus_read(3'd0, rd);  check("rx_data", rd, rx_vals[i]);
        end
        bus_read(3'd1, rd);  check("rx_status_empty_ovr", rd, 8'h0C);
        bus_write(3'd1, 8'h08);
        bus_read(3'd1, rd);  check("rx_ovr_cleared", rd, 8'h04);

        // ---- Simultaneous pop and push on full RX FIFO ----
        rx_byte(8'hA1); rx_byte(8'hA2); rx_byte(8'hA3); rx_byte(8'hA4);
        bus_read(3'd1, rd);  check("rx_full_status", rd, 8'h05);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 3'd0; bytercvd = 1'b1; rxq = 8'h99;
        @(negedge clk);
        cs = 1'b0; bytercvd = 1'b0;
        check("sim_pop_data", dout, 8'hA1);
        bus_read(3'd1, rd);  check("sim_no_overrun", rd, 8'h05);
        for (int i = 0; i < 5; i++) begin
            bus_read(3'd0, rd);  check("sim_data", rd, full_vals[i]);
        end

        // ---- IRQ ----
        bus_write(3'd4, 8'h01);
        @(negedge clk);
        check("irq_rx_empty", irq, 1'b0);
        rx_byte(8'h5A);
        check("irq_lag", irq, 1'b0);
        @(negedge clk);
        check("irq_rx", irq, 1'b1);
        bus_read(3'd0, rd);  check("irq_rx_data", rd, 8'h5A);
        @(negedge clk);
        check("irq_rx_cleared", irq, 1'b0);
        bus_write(3'd4, 8'h02);
        @(negedge clk);
        check("irq_tx_empty", irq, 1'b1);
        bus_read(3'd4, rd);  check("ctrl_readback", rd, 8'h02);
        bus_write(3'd4, 8'h00);
        @(negedge clk);
        check("irq_disabled", irq, 1'b0);
        bus_read(3'd6, rd);  check("unused_reg", rd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
